ahci_slot_sched: RTL and testbench
==================================

Name: ahci_slot_sched

Overview:
- Parametrised successor of the single-slot port-0 command FSM; generalises PxCI from one bit to NUM_SLOTS command slots.
- Owns the PxCI vector, the PxCMD.CR run flag and PxCMD.CCS.
- Picks the next pending slot round-robin and hands it to the command fetch/transmit engine over a valid/ready handshake.
- Retires slots on completion, detects stuck commands with an optional watchdog, and holds in an error state until software clears PxCMD.ST.

Parameters:
- NUM_SLOTS, 32, number of command slots (1..32).
- SLOT_BITS, 5, slot index width; must be >= clog2(NUM_SLOTS), minimum 1.
- WDOG_BITS, 20, width of the per-command watchdog counter.

Ports:
- mclk  in  1  clock.
- hba_rst_n  in  1  reset, synchronous, active-low.
- pcmd_st  in  1  PxCMD.ST current value.
- pxci_set  in  NUM_SLOTS  one-cycle pulse; software wrote 1s to PxCI.
- pxci  out  NUM_SLOTS  current PxCI.
- pcmd_cr  out  1  PxCMD.CR, command list running.
- ccs  out  SLOT_BITS  PxCMD.CCS, last issued slot.
- issue_vld  out  1  slot offered to the fetch engine.
- issue_slot  out  SLOT_BITS  offered slot, stable while issue_vld is high.
- issue_rdy  in  1  fetch engine accepts the offer.
- cmd_done  in  1  pulse; in-flight command finished.
- cmd_err  in  1  qualifies cmd_done; command ended with error (TFE/IF).
- done_vld  out  1  pulse; slot retired or failed.
- done_slot  out  SLOT_BITS  slot reported with done_vld.
- done_err  out  1  done_vld was caused by an error or timeout.
- timeout_irq  out  1  pulse on watchdog expiry.
- sched_err  out  1  high while in state ERR.

Behaviour:
- Reset (hba_rst_n=0 at posedge mclk) forces:
  - pxci=0, pcmd_cr=0, ccs=0, issue_vld=0, issue_slot=0.
  - done_vld=0, done_slot=0, done_err=0, timeout_irq=0, sched_err=0.
  - Internal round-robin pointer rr=0, state IDLE, watchdog=0.
  - Reset mid-command abandons the command silently; no done_vld is produced.
- States: IDLE, SCAN, ISSUE, WAIT, ERR. All outputs are registered.
- IDLE:
  - pcmd_cr=0; pxci_set is ignored.
  - pcmd_st=1 moves to SCAN, and pcmd_cr=1 from the next cycle.
- SCAN:
  - pcmd_st=0 moves to IDLE and clears pxci and ccs.
  - Otherwise, if pxci != 0, select the first set bit searching from rr upward, wrapping at NUM_SLOTS-1 to 0.
  - Register issue_slot = selected slot and ccs = selected slot, set rr = selected+1 (mod NUM_SLOTS), and move to ISSUE with issue_vld=1 on the next cycle.
  - SCAN to ISSUE latency: 1 cycle.
- ISSUE:
  - issue_vld is held with issue_slot stable until issue_rdy.
  - A cycle with issue_vld&issue_rdy moves to WAIT, drops issue_vld and clears the watchdog.
  - pcmd_st=0 before acceptance drops issue_vld and moves to IDLE (clears pxci).
- WAIT:
  - Plain cmd_done clears pxci[issue_slot], pulses done_vld (done_err=0) and moves to SCAN.
  - cmd_done&cmd_err keeps pxci, pulses done_vld with done_err=1 and moves to ERR.
  - pcmd_st=0 during WAIT does not abort; the block keeps waiting for cmd_done or timeout, then goes to IDLE (clears pxci) instead of SCAN/ERR.
  - A cmd_done outside WAIT is ignored.
- ERR:
  - sched_err=1, pcmd_cr stays 1, and pxci keeps accepting sets.
  - pcmd_st=0 moves to IDLE: clears pxci, ccs and sched_err, sets pcmd_cr=0.
- pxci update each cycle: pxci = (pxci & ~clear_mask) | (pxci_set & {NUM_SLOTS{state!=IDLE}}).
  - Set wins over a simultaneous clear of the same bit.
- done_vld, timeout_irq: exactly 1 cycle wide.
- Bits of pxci_set above NUM_SLOTS-1 do not exist; selected slot indices are zero-extended to SLOT_BITS.

Optional Feature:
- Macro: AHCI_SLOT_WDOG_EN.
- Defined:
  - WDOG_BITS counter increments every cycle in WAIT and saturates.
  - Reaching all-ones without cmd_done pulses timeout_irq and done_vld with done_err=1, keeps pxci, and moves to ERR (IDLE if pcmd_st=0).
  - cmd_done in the same cycle as expiry takes priority and no timeout is raised.
- Undefined: no counter; timeout_irq tied 0; WAIT exits only on cmd_done.

Test Plan:
- Basic issue, NUM_SLOTS=32: reset, pcmd_st=1, pxci_set=0x0000_0001, issue_rdy=1, cmd_done 5 cycles later -> issue_slot=0, ccs=0, done_vld with done_slot=0 and done_err=0, pxci=0, pcmd_cr=1.
- Round-robin: pxci_set=0x8000_0005 with rr=0 -> issue order 0, 2, 31; then pxci_set=0x1 -> slot 0 (wrap); rr=1 after.
- Error: slot 3 in WAIT, cmd_done&cmd_err -> done_err=1, sched_err=1, pxci[3] stays 1, no new issue_vld; pcmd_st=0 -> pxci=0, pcmd_cr=0, ccs=0.
- Stop mid-command: pcmd_st=0 in ISSUE with issue_rdy=0 -> issue_vld drops next cycle, IDLE. Same in WAIT -> remains WAIT until cmd_done, then pxci=0, pcmd_cr=0.
- Set/clear collision: pxci_set=bit 4 in the same cycle as cmd_done for slot 4 -> pxci[4]=1 afterwards and slot 4 reissued. Reset asserted during WAIT -> all outputs 0 next cycle, no done_vld.
- Watchdog, AHCI_SLOT_WDOG_EN defined, WDOG_BITS=4: no cmd_done -> timeout_irq and done_vld with done_err=1 exactly 15 cycles after acceptance, state ERR. Undefined -> no pulse after 1000 cycles.

Source files
------------

// File: rtl/ahci_slot_sched.sv
// Purpose: AHCI port command-slot scheduler; owns PxCI, PxCMD.CR and PxCMD.CCS and issues pending slots round-robin.
// Latency: SCAN to issue_vld is 1 cycle; done_vld follows cmd_done by 1 cycle; all outputs registered.
// Backpressure: issue_vld/issue_slot hold until issue_rdy; one command in flight. Optional watchdog: AHCI_SLOT_WDOG_EN.
module ahci_slot_sched #(
    parameter int NUM_SLOTS = 32,
    parameter int SLOT_BITS = 5,
    parameter int WDOG_BITS = 20
) (
    input  logic                 mclk,
    input  logic                 hba_rst_n,
    input  logic                 pcmd_st,
    input  logic [NUM_SLOTS-1:0] pxci_set,
    output logic [NUM_SLOTS-1:0] pxci,
    output logic                 pcmd_cr,
    output logic [SLOT_BITS-1:0] ccs,
    output logic                 issue_vld,
    output logic [SLOT_BITS-1:0] issue_slot,
    input  logic                 issue_rdy,
    input  logic                 cmd_done,
    input  logic                 cmd_err,
    output logic                 done_vld,
    output logic [SLOT_BITS-1:0] done_slot,
    output logic                 done_err,
    output logic                 timeout_irq,
    output logic                 sched_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t               state_q, state_n;
    logic [SLOT_BITS-1:0] rr_q, rr_n;

    logic [NUM_SLOTS-1:0] pxci_n, pxci_clr;
    logic                 pcmd_cr_n;
    logic [SLOT_BITS-1:0] ccs_n;
    logic                 issue_vld_n;
    logic [SLOT_BITS-1:0] issue_slot_n;
    logic                 done_vld_n;
    logic [SLOT_BITS-1:0] done_slot_n;
    logic                 done_err_n;
    logic                 timeout_irq_n;
    logic                 sched_err_n;

    logic                 sel_found;
    logic [SLOT_BITS-1:0] sel_slot;
    logic                 fin, fail;

`ifdef AHCI_SLOT_WDOG_EN
    localparam logic [WDOG_BITS-1:0] WDOG_MAX  = '1;
    localparam logic [WDOG_BITS-1:0] WDOG_LAST = WDOG_MAX - WDOG_BITS'(1);
    logic [WDOG_BITS-1:0] wdog_q, wdog_n;
`endif

    // Slot index base+off, wrapped into 0..NUM_SLOTS-1.
    function automatic logic [SLOT_BITS-1:0] wrap_idx(input logic [SLOT_BITS-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
        return s[SLOT_BITS-1:0];
    endfunction

    // Round-robin pick: first pending slot at or above rr, wrapping to 0.
    always_comb begin
        sel_found = 1'b0;
        sel_slot  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!sel_found && pxci[wrap_idx(rr_q, i)]) begin
                sel_found = 1'b1;
                sel_slot  = wrap_idx(rr_q, i);
            end
        end
    end

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_n       = state_q;
        rr_n          = rr_q;
        pxci_clr      = '0;
        pcmd_cr_n     = pcmd_cr;
        ccs_n         = ccs;
        issue_vld_n   = issue_vld;
        issue_slot_n  = issue_slot;
        done_vld_n    = 1'b0;
        done_slot_n   = done_slot;
        done_err_n    = done_err;
        timeout_irq_n = 1'b0;
        sched_err_n   = sched_err;
        fin           = 1'b0;
        fail          = 1'b0;
`ifdef AHCI_SLOT_WDOG_EN
        wdog_n        = wdog_q;
`endif
        case (state_q)
            S_IDLE: begin
                pcmd_cr_n = 1'b0;
                if (pcmd_st) begin
                    state_n   = S_SCAN;
                    pcmd_cr_n = 1'b1;
                end
            end
            S_SCAN: begin
                if (!pcmd_st) begin
                    state_n   = S_IDLE;
                    pxci_clr  = '1;
                    ccs_n     = '0;
                    pcmd_cr_n = 1'b0;
                end else if (sel_found) begin
                    state_n      = S_ISSUE;
                    issue_slot_n = sel_slot;
                    ccs_n        = sel_slot;
                    rr_n         = wrap_idx(sel_slot, 1);
                    issue_vld_n  = 1'b1;
                end
            end
            S_ISSUE: begin
                // Acceptance wins over a simultaneous stop: the slot is already handed off.
                if (issue_rdy) begin
                    state_n     = S_WAIT;
                    issue_vld_n = 1'b0;
`ifdef AHCI_SLOT_WDOG_EN
                    wdog_n      = '0;
`endif
                end else if (!pcmd_st) begin
                    state_n     = S_IDLE;
                    issue_vld_n = 1'b0;
                    pxci_clr    = '1;
                    pcmd_cr_n   = 1'b0;
                end
            end
            S_WAIT: begin
`ifdef AHCI_SLOT_WDOG_EN
                if (wdog_q != WDOG_MAX) wdog_n = wdog_q + WDOG_BITS'(1);
`endif
                if (cmd_done) begin
                    fin  = 1'b1;
                    fail = cmd_err;
                end
`ifdef AHCI_SLOT_WDOG_EN
                else if (wdog_q == WDOG_LAST) begin
                    fin           = 1'b1;
                    fail          = 1'b1;
                    timeout_irq_n = 1'b1;
                end
`endif
                if (fin) begin
                    done_vld_n  = 1'b1;
                    done_slot_n = issue_slot;
                    done_err_n  = fail;
                    // A stop requested while the command was in flight is honoured only now.
                    if (!pcmd_st) begin
                        state_n   = S_IDLE;
                        pxci_clr  = '1;
                        pcmd_cr_n = 1'b0;
                    end else if (fail) begin
                        state_n     = S_ERR;
                        sched_err_n = 1'b1;
                    end else begin
                        state_n  = S_SCAN;
                        pxci_clr = NUM_SLOTS'(1) << issue_slot;
                    end
                end
            end
            S_ERR: begin
                sched_err_n = 1'b1;
                if (!pcmd_st) begin
                    state_n     = S_IDLE;
                    pxci_clr    = '1;
                    ccs_n       = '0;
                    sched_err_n = 1'b0;
                    pcmd_cr_n   = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        // Software set wins over a same-cycle clear of the same bit; sets are dropped while idle.
        pxci_n = (pxci & ~pxci_clr) | (pxci_set & {NUM_SLOTS{state_q != S_IDLE}});
    end

    // State register and registered outputs, synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!hba_rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            pxci        <= '0;
            pcmd_cr     <= 1'b0;
            ccs         <= '0;
            issue_vld   <= 1'b0;
            issue_slot  <= '0;
            done_vld    <= 1'b0;
            done_slot   <= '0;
            done_err    <= 1'b0;
            timeout_irq <= 1'b0;
            sched_err   <= 1'b0;
`ifdef AHCI_SLOT_WDOG_EN
            wdog_q      <= '0;
`endif
        end else begin
            state_q     <= state_n;
            rr_q        <= rr_n;
            pxci        <= pxci_n;
            pcmd_cr     <= pcmd_cr_n;
            ccs         <= ccs_n;
            issue_vld   <= issue_vld_n;
            issue_slot  <= issue_slot_n;
            done_vld    <= done_vld_n;
            done_slot   <= done_slot_n;
            done_err    <= done_err_n;
            timeout_irq <= timeout_irq_n;
            sched_err   <= sched_err_n;
`ifdef AHCI_SLOT_WDOG_EN
            wdog_q      <= wdog_n;
`endif
        end
    end

endmodule

// File: tb/tb_ahci_slot_sched.sv
// Bench for ahci_slot_sched: directed corner sequences, a round-robin vector table and a random run.
// A slot-level reference model tracks pending bits, the offer, the in-flight command and the fault flag.
// Every cycle the DUT outputs are compared against that model in addition to the directed checks.
module tb_ahci_slot_sched;
    localparam int N  = 32;
    localparam int SB = 5;
    localparam int WB = 4;
`ifdef AHCI_SLOT_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          mclk = 1'b0;
    logic          hba_rst_n, pcmd_st, issue_rdy, cmd_done, cmd_err;
    logic [N-1:0]  pxci_set, pxci;
    logic          pcmd_cr, issue_vld, done_vld, done_err, timeout_irq, sched_err;
    logic [SB-1:0] ccs, issue_slot, done_slot;

    always #5 mclk = ~mclk;

    ahci_slot_sched #(.NUM_SLOTS(N), .SLOT_BITS(SB), .WDOG_BITS(WB)) dut (
        .mclk(mclk), .hba_rst_n(hba_rst_n), .pcmd_st(pcmd_st), .pxci_set(pxci_set),
        .pxci(pxci), .pcmd_cr(pcmd_cr), .ccs(ccs), .issue_vld(issue_vld),
        .issue_slot(issue_slot), .issue_rdy(issue_rdy), .cmd_done(cmd_done),
        .cmd_err(cmd_err), .done_vld(done_vld), .done_slot(done_slot),
        .done_err(done_err), .timeout_irq(timeout_irq), .sched_err(sched_err)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [52:0] outs();
        return {pxci, pcmd_cr, ccs, issue_vld, issue_slot, done_vld, done_slot, done_err, timeout_irq, sched_err};
    endfunction

    // ---------------- reference model (slot-level view) ----------------
    bit         m_on = 0, m_offer = 0, m_busy = 0, m_fault = 0;
    bit         m_dvld = 0, m_derr = 0, m_tirq = 0;
    bit [N-1:0] m_pend = '0, m_clr;
    int         m_ptr = 0, m_slot = 0, m_ccs = 0, m_dslot = 0, m_age = 0;
    bit         m_was_on, m_to, m_found;

    always @(posedge mclk) begin
        if (!hba_rst_n) begin
            m_on = 0; m_offer = 0; m_busy = 0; m_fault = 0; m_dvld = 0; m_derr = 0; m_tirq = 0;
            m_pend = '0; m_ptr = 0; m_slot = 0; m_ccs = 0; m_dslot = 0; m_age = 0;
        end else begin
            m_was_on = m_on;
            m_clr = '0;
            m_dvld = 0;
            m_tirq = 0;
            if (!m_on) begin
                if (pcmd_st) m_on = 1;
            end else if (m_fault) begin
                if (!pcmd_st) begin m_clr = '1; m_ccs = 0; m_fault = 0; m_on = 0; end
            end else if (m_offer) begin
                if (issue_rdy) begin m_offer = 0; m_busy = 1; m_age = 0; end
                else if (!pcmd_st) begin m_offer = 0; m_clr = '1; m_on = 0; end
            end else if (m_busy) begin
                m_age = m_age + 1;
                m_to = WD && !cmd_done && (m_age == (1 << WB) - 1);
                if (cmd_done || m_to) begin
                    m_busy = 0; m_dvld = 1; m_dslot = m_slot;
                    m_derr = m_to || cmd_err; m_tirq = m_to;
                    if (!pcmd_st) begin m_clr = '1; m_on = 0; end
                    else if (m_derr) m_fault = 1;
                    else m_clr[m_slot] = 1'b1;
                end
            end else begin
                if (!pcmd_st) begin m_clr = '1; m_ccs = 0; m_on = 0; end
                else if (m_pend != '0) begin
                    m_found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!m_found && m_pend[(m_ptr + k) % N]) begin
                            m_found = 1;
                            m_slot = (m_ptr + k) % N;
                        end
                    end
                    m_ccs = m_slot; m_ptr = (m_slot + 1) % N; m_offer = 1;
                end
            end
            m_pend = (m_pend & ~m_clr) | (m_was_on ? pxci_set : '0);
        end
    end

    logic [52:0] exp_v;
    always @(negedge mclk) begin
        if (mon_en) begin
            exp_v = {m_pend, m_on, SB'(m_ccs), m_offer, SB'(m_slot), m_dvld, SB'(m_dslot), m_derr, m_tirq, m_fault};
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t: dut pxci=%h cr=%b ccs=%0d vld=%b slot=%0d dv=%b ds=%0d de=%b to=%b se=%b | want pxci=%h cr=%b ccs=%0d vld=%b slot=%0d dv=%b ds=%0d de=%b to=%b se=%b",
                         $time, pxci, pcmd_cr, ccs, issue_vld, issue_slot, done_vld, done_slot, done_err, timeout_irq, sched_err,
                         m_pend, m_on, m_ccs, m_offer, m_slot, m_dvld, m_dslot, m_derr, m_tirq, m_fault);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge mclk);
    endtask

    task automatic wait_vld();
        int n = 0;
        while (!issue_vld && n < 40) begin tick(); n++; end
        check("issue_vld_seen", issue_vld, 1);
    endtask

    // Accept the offered slot and complete it cleanly; returns the slot seen.
    task automatic run_one(output int s);
        wait_vld();
        s = int'(issue_slot);
        issue_rdy = 1; tick();
        cmd_done = 1; tick(); cmd_done = 0;
        check("rr_done_vld", done_vld, 1);
        check("rr_done_slot", done_slot, s);
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           n;
        logic [14:0]  seq;   // expected slots, first in [4:0]
    } rr_vec_t;
    rr_vec_t tbl[6];

    int s, hit;
    bit seen;

    initial begin
        tbl[0] = '{32'h8000_0005, 3, {5'd31, 5'd2, 5'd0}};
        tbl[1] = '{32'h0000_0001, 1, {5'd0, 5'd0, 5'd0}};
        tbl[2] = '{32'h0000_0011, 2, {5'd0, 5'd0, 5'd4}};
        tbl[3] = '{32'h0000_0003, 2, {5'd0, 5'd0, 5'd1}};
        tbl[4] = '{32'h4000_0002, 2, {5'd0, 5'd30, 5'd1}};
        tbl[5] = '{32'h8000_0001, 2, {5'd0, 5'd0, 5'd31}};

        hba_rst_n = 0; pcmd_st = 0; pxci_set = '0; issue_rdy = 0; cmd_done = 0; cmd_err = 0;
        repeat (2) tick();
        mon_en = 1;
        check("reset_outputs", outs(), 0);

        // Idle ignores PxCI writes.
        hba_rst_n = 1; pxci_set = 32'h1; tick(); pxci_set = '0;
        check("idle_ignores_set", pxci, 0);
        check("idle_cr", pcmd_cr, 0);

        // Basic single issue.
        pcmd_st = 1; tick();
        check("start_cr", pcmd_cr, 1);
        pxci_set = 32'h1; issue_rdy = 1; tick(); pxci_set = '0;
        wait_vld();
        check("basic_slot", issue_slot, 0);
        check("basic_ccs", ccs, 0);
        tick();
        check("basic_vld_drop", issue_vld, 0);
        repeat (4) tick();
        cmd_done = 1; tick(); cmd_done = 0;
        check("basic_done_vld", done_vld, 1);
        check("basic_done_slot", done_slot, 0);
        check("basic_done_err", done_err, 0);
        check("basic_pxci", pxci, 0);
        check("basic_cr", pcmd_cr, 1);
        tick();
        check("basic_done_1cyc", done_vld, 0);

        // Round-robin table from rr=0.
        hba_rst_n = 0; tick(); hba_rst_n = 1; tick();
        for (int e = 0; e < 6; e++) begin
            pxci_set = tbl[e].mask; tick(); pxci_set = '0;
            for (int j = 0; j < tbl[e].n; j++) begin
                run_one(s);
                check($sformatf("rr_vec%0d_issue%0d", e, j), s, tbl[e].seq[j*5 +: 5]);
            end
        end

        // Error completion holds in ERR until ST drops.
        pxci_set = 32'h8; tick(); pxci_set = '0;
        wait_vld();
        check("err_slot", issue_slot, 3);
        tick(); tick();
        cmd_done = 1; cmd_err = 1; tick(); cmd_done = 0; cmd_err = 0;
        check("err_done_vld", done_vld, 1);
        check("err_done_err", done_err, 1);
        check("err_done_slot", done_slot, 3);
        check("err_pxci3_kept", pxci[3], 1);
        check("err_sched_err", sched_err, 1);
        seen = 0;
        pxci_set = 32'h200;
        for (int c = 0; c < 6; c++) begin tick(); pxci_set = '0; seen |= issue_vld; end
        check("err_no_issue", seen, 0);
        check("err_set_accepted", pxci[9], 1);
        check("err_cr", pcmd_cr, 1);
        pcmd_st = 0; tick();
        check("err_stop_pxci", pxci, 0);
        check("err_stop_cr", pcmd_cr, 0);
        check("err_stop_ccs", ccs, 0);
        check("err_stop_sched", sched_err, 0);

        // Stop while offering.
        pcmd_st = 1; issue_rdy = 0; tick();
        pxci_set = 32'h40; tick(); pxci_set = '0;
        wait_vld();
        repeat (2) tick();
        check("hold_vld", issue_vld, 1);
        check("hold_slot", issue_slot, 6);
        pcmd_st = 0; tick();
        check("stop_issue_vld", issue_vld, 0);
        check("stop_issue_cr", pcmd_cr, 0);
        check("stop_issue_pxci", pxci, 0);

        // Stop while in flight: keeps waiting for completion.
        pcmd_st = 1; tick();
        pxci_set = 32'h80; issue_rdy = 1; tick(); pxci_set = '0;
        wait_vld(); tick();
        pcmd_st = 0;
        repeat (3) tick();
        check("stop_wait_cr", pcmd_cr, 1);
        check("stop_wait_pxci", pxci[7], 1);
        cmd_done = 1; tick(); cmd_done = 0;
        check("stop_wait_done", done_vld, 1);
        check("stop_wait_pxci0", pxci, 0);
        check("stop_wait_cr0", pcmd_cr, 0);

        // Set/clear collision on the completing slot.
        pcmd_st = 1; tick();
        pxci_set = 32'h10; tick(); pxci_set = '0;
        wait_vld(); tick(); tick();
        cmd_done = 1; pxci_set = 32'h10; tick(); cmd_done = 0; pxci_set = '0;
        check("coll_done", done_vld, 1);
        check("coll_pxci4", pxci[4], 1);
        wait_vld();
        check("coll_reissue", issue_slot, 4);

        // Reset in flight abandons silently.
        tick(); tick();
        hba_rst_n = 0; tick(); hba_rst_n = 1;
        check("rst_wait_outputs", outs(), 0);
        cmd_done = 1; tick(); cmd_done = 0;
        check("done_outside_wait", done_vld, 0);

        // Watchdog.
        pcmd_st = 1; tick();
        pxci_set = 32'h4; tick(); pxci_set = '0;
        wait_vld(); tick();
        hit = 0;
        for (int c = 1; c <= 1000 && hit == 0; c++) begin
            tick();
            if (timeout_irq) begin
                hit = c;
                check("wd_done_vld", done_vld, 1);
                check("wd_done_err", done_err, 1);
                check("wd_sched_err", sched_err, 1);
                check("wd_pxci_kept", pxci[2], 1);
            end
        end
        if (WD) begin
            check("wd_cycles", hit, 15);
            tick();
            check("wd_irq_1cyc", timeout_irq, 0);
        end else begin
            check("no_wd_irq", hit, 0);
            check("no_wd_still_busy", pcmd_cr, 1);
            cmd_done = 1; tick(); cmd_done = 0;
            check("no_wd_done", done_vld, 1);
        end
        pcmd_st = 0; tick(); tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            hba_rst_n = ($urandom_range(0, 299) != 0);
            if (pcmd_st) pcmd_st = ($urandom_range(0, 49) != 0);
            else         pcmd_st = ($urandom_range(0, 3) == 0);
            pxci_set  = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : '0;
            issue_rdy = ($urandom_range(0, 2) != 0);
            cmd_done  = ($urandom_range(0, 4) == 0);
            cmd_err   = cmd_done && ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
